// File: rtl/register_formatter.sv
// register_formatter
// Converts a 5-bit register number (0-31) into an ASCII character stream:
// optional prefix, two decimal digits (always with a leading zero), and an
// optional terminator. Digits are produced by repeated subtraction of 10.
//
// Optional feature macro: REGISTER_FORMATTER_PREFIX_EN
//   defined   -> PREFIX state present, PREFIX_CHAR emitted before the digits
//   undefined -> PREFIX state absent, PREFIX_CHAR unused
//
// Handshakes: a request is taken on a rising edge where valid_in && ready_out;
// a character is taken on a rising edge where ascii_valid_out &&
// ascii_ready_in. ascii_out holds stable while the character is not taken.
// All outputs decode from registered state only, so none of them depends
// combinationally on ascii_ready_in.
module register_formatter #(
  parameter logic [7:0] PREFIX_CHAR = 8'h78
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       valid_in,
  input  logic [4:0] register_in,
  input  logic [1:0] sep_sel_in,
  output logic       ready_out,
  output logic [7:0] ascii_out,
  output logic       ascii_valid_out,
  input  logic       ascii_ready_in,
  output logic       busy_flag,
  output logic       done_flag
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
`ifdef REGISTER_FORMATTER_PREFIX_EN
    PREFIX  = 3'd2,
`endif
    TENS    = 3'd3,
    ONES    = 3'd4,
    SEP     = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [4:0] rem_q;   // latched register, reduced to the ones digit
  logic [1:0] tens_q;  // tens digit, at most 3
  logic [1:0] sep_q;   // latched terminator select

  logic       char_taken;
  assign char_taken = ascii_valid_out && ascii_ready_in;

`ifndef REGISTER_FORMATTER_PREFIX_EN
  // The prefix character only matters when the prefix state exists.
  logic unused_prefix;
  assign unused_prefix = ^PREFIX_CHAR;
`endif

  // State register; reset aborts any sequence in progress.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Datapath: latch on accept, then subtract tens during CONVERT.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rem_q  <= 5'd0;
      tens_q <= 2'd0;
      sep_q  <= 2'd0;
    end else if (state_q == IDLE && valid_in) begin
      rem_q  <= register_in;
      tens_q <= 2'd0;
      sep_q  <= sep_sel_in;
    end else if (state_q == CONVERT && rem_q >= 5'd10) begin
      rem_q  <= rem_q - 5'd10;
      tens_q <= tens_q + 2'd1;
    end
  end

  // Next-state logic; character states advance only when the char is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_in) state_d = CONVERT;
      CONVERT: begin
        if (rem_q < 5'd10) begin
`ifdef REGISTER_FORMATTER_PREFIX_EN
          state_d = PREFIX;
`else
          state_d = TENS;
`endif
        end
      end
`ifdef REGISTER_FORMATTER_PREFIX_EN
      PREFIX:  if (char_taken) state_d = TENS;
`endif
      TENS:    if (char_taken) state_d = ONES;
      ONES:    if (char_taken) state_d = (sep_q == 2'b00) ? DONE : SEP;
      SEP:     if (char_taken) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state and latched data.
  always_comb begin
    ready_out       = 1'b0;
    ascii_out       = 8'h00;
    ascii_valid_out = 1'b0;
    busy_flag       = 1'b1;
    done_flag       = 1'b0;
    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        busy_flag = 1'b0;
      end
`ifdef REGISTER_FORMATTER_PREFIX_EN
      PREFIX: begin
        ascii_valid_out = 1'b1;
        ascii_out       = PREFIX_CHAR;
      end
`endif
      TENS: begin
        ascii_valid_out = 1'b1;
        ascii_out       = 8'h30 + {6'd0, tens_q};
      end
      ONES: begin
        ascii_valid_out = 1'b1;
        ascii_out       = 8'h30 + {3'd0, rem_q};
      end
      SEP: begin
        ascii_valid_out = 1'b1;
        case (sep_q)
          2'b01:   ascii_out = 8'h20;
          2'b10:   ascii_out = 8'h2C;
          2'b11:   ascii_out = 8'h0A;
          default: ascii_out = 8'h00;
        endcase
      end
      DONE: done_flag = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_register_formatter.sv
// Directed bench for register_formatter. Inputs change 1 time unit after the
// rising edge; outputs are sampled either then (state just settled) or on the
// falling edge by the character monitor.
module tb_register_formatter;

  // ---------------- clock / reset ----------------
  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       valid_in = 1'b0;
  logic [4:0] register_in = 5'd0;
  logic [1:0] sep_sel_in = 2'b00;
  logic       ready_out;
  logic [7:0] ascii_out;
  logic       ascii_valid_out;
  logic       ascii_ready_in = 1'b1;
  logic       busy_flag;
  logic       done_flag;

  always #5 clk_in = ~clk_in;

  register_formatter #(.PREFIX_CHAR(8'h78)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .valid_in        (valid_in),
    .register_in     (register_in),
    .sep_sel_in      (sep_sel_in),
    .ready_out       (ready_out),
    .ascii_out       (ascii_out),
    .ascii_valid_out (ascii_valid_out),
    .ascii_ready_in  (ascii_ready_in),
    .busy_flag       (busy_flag),
    .done_flag       (done_flag)
  );

`ifdef REGISTER_FORMATTER_PREFIX_EN
  localparam int PFX_N = 1;
`else
  localparam int PFX_N = 0;
`endif

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_exp(input int r, input logic [1:0] s);
    logic [7:0] t;
    logic [7:0] o;
    t = 8'h30 + 8'(r / 10);
    o = 8'h30 + 8'(r % 10);
`ifdef REGISTER_FORMATTER_PREFIX_EN
    exp_q.push_back(8'h78);
`endif
    exp_q.push_back(t);
    exp_q.push_back(o);
    case (s)
      2'b01: exp_q.push_back(8'h20);
      2'b10: exp_q.push_back(8'h2C);
      2'b11: exp_q.push_back(8'h0A);
      default: ;
    endcase
  endtask

  task automatic send(input int r, input logic [1:0] s);
    chk("send_ready", ready_out, 1);
    valid_in    = 1'b1;
    register_in = 5'(r);
    sep_sel_in  = s;
    tick();
    valid_in    = 1'b0;
    chk("send_busy", busy_flag, 1);
  endtask

  // Full request with ready_in held high: checks first-char latency,
  // accept-to-done cycle count and the single-cycle done pulse.
  task automatic run_req(input int r, input logic [1:0] s);
    int n;
    int conv;
    int nch;
    conv = r / 10 + 1;
    nch  = PFX_N + 2 + ((s != 2'b00) ? 1 : 0);
    push_exp(r, s);
    send(r, s);
    n = 0;
    while (!ascii_valid_out && n < 20) begin tick(); n++; end
    chk("latency", n, conv);
    n = n + 1;
    while (!done_flag && n < 40) begin tick(); n++; end
    chk("total_cycles", n, conv + nch + 1);
    tick();
    chk("done_one_cycle", done_flag, 0);
    chk("ready_after_done", ready_out, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_in) begin
    if (rst_n_in && ascii_valid_out && ascii_ready_in) begin
      if (exp_q.size() == 0) chk("extra_char", {24'd0, ascii_out}, 32'h100);
      else                   chk("char", {24'd0, ascii_out}, {24'd0, exp_q.pop_front()});
    end
    if (rst_n_in && done_flag) done_count++;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int dc;
    #3;
    chk("rst_ready", ready_out, 1);
    chk("rst_valid", ascii_valid_out, 0);
    chk("rst_ascii", ascii_out, 0);
    chk("rst_busy", busy_flag, 0);
    chk("rst_done", done_flag, 0);
    tick();
    rst_n_in = 1'b1;
    tick();
    chk("idle_ready", ready_out, 1);

    // r=31, terminator ','
    run_req(31, 2'b10);
    // r=0, no terminator: 1 convert cycle, 4 cycles accept to done
    run_req(0, 2'b00);
    // r=5 leading zero, r=10 and r=29 boundaries
    run_req(5, 2'b01);
    run_req(10, 2'b11);
    run_req(29, 2'b10);

    // r=19 with tens character stalled for 3 cycles
    push_exp(19, 2'b01);
    send(19, 2'b01);
    n = 0;
    while (!ascii_valid_out && n < 20) begin tick(); n++; end
    chk("stall_latency", n, 2);
`ifdef REGISTER_FORMATTER_PREFIX_EN
    chk("stall_prefix", ascii_out, 8'h78);
    tick();
`endif
    chk("stall_tens", ascii_out, 8'h31);
    ascii_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", ascii_out, 8'h31);
      chk("stall_valid", ascii_valid_out, 1);
    end
    ascii_ready_in = 1'b1;
    tick();
    chk("stall_ones", ascii_out, 8'h39);
    tick();
    chk("stall_sep", ascii_out, 8'h20);
    tick();
    chk("stall_done", done_flag, 1);
    tick();
    chk("stall_queue_empty", exp_q.size(), 0);

    // r=7 pulsed while busy with r=22: must be ignored
    dc = done_count;
    push_exp(22, 2'b00);
    send(22, 2'b00);
    tick();
    chk("busy_not_ready", ready_out, 0);
    valid_in    = 1'b1;
    register_in = 5'd7;
    sep_sel_in  = 2'b11;
    tick();
    valid_in    = 1'b0;
    n = 0;
    while (!done_flag && n < 40) begin tick(); n++; end
    chk("busy_done_seen", done_flag, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("busy_no_extra", ascii_valid_out, 0);
      tick();
    end
    chk("busy_queue_empty", exp_q.size(), 0);
    chk("busy_done_count", done_count - dc, 1);

    // reset asserted during ONES of r=12
    push_exp(12, 2'b00);
    send(12, 2'b00);
    n = 0;
    while (!(ascii_valid_out && ascii_out == 8'h32) && n < 20) begin tick(); n++; end
    chk("rst_mid_ones", ascii_out, 8'h32);
    dc = done_count;
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("rst_mid_valid", ascii_valid_out, 0);
    chk("rst_mid_ready", ready_out, 1);
    chk("rst_mid_busy", busy_flag, 0);
    chk("rst_mid_ascii", ascii_out, 0);
    exp_q.delete();
    tick();
    tick();
    rst_n_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_after_idle", ascii_valid_out, 0);
    end
    chk("rst_no_done", done_count - dc, 0);

    // sweep all register numbers with newline terminator
    for (int r = 0; r < 32; r++) run_req(r, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
